instr_fetch: RTL and testbench

//  Fetch stage upstream of the datapath's instruction port. Takes PC, returns Instr from an

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Memory-side request/acknowledge bus of the instruction fetch stage.
// Master issues word reads; slave accepts with a one-cycle ack plus data.
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Two-entry instruction fetch stage: current word plus next-line prefetch,
// variable-latency memory over req/ack, stall on miss, sticky timeout flag.
module instr_fetch #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = 32'hE1A00000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          stall,
  output logic          fetch_err,
  instr_fetch_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic {
    DEMAND,
    PREF
  } kind_e;

  typedef struct packed {
    logic [29:0] tag;
    logic [31:0] data;
    logic        v;
  } entry_t;

  entry_t        cur_q, cur_d;
  entry_t        nxt_q, nxt_d;
  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic          req_q, req_d;
  logic [29:0]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [29:0] pc_tag;
  logic        hitc;
  logic        hitn;
  logic        hit;
  logic [29:0] eff_tag;
  logic        nxt_leads;
  logic        pref_need;
  logic        unused_pc;

  assign pc_tag    = pc[31:2];
  assign unused_pc = ^pc[1:0];

  assign hitc = cur_q.v && (cur_q.tag == pc_tag);
  assign hitn = nxt_q.v && (nxt_q.tag == pc_tag);
  assign hit  = hitc || hitn;

  // After a promotion nxt is emptied, so only a cur hit can already be led.
  assign eff_tag   = hitc ? cur_q.tag : nxt_q.tag;
  assign nxt_leads = hitc && nxt_q.v &&
                     (nxt_q.tag == cur_q.tag + 30'd1);
  assign pref_need = hit && !nxt_leads;

  always_comb begin
    instr = NOP_INSTR;
    unique case (1'b1)
      hitc:    instr = cur_q.data;
      hitn:    instr = nxt_q.data;
      default: instr = NOP_INSTR;
    endcase
  end

  assign stall       = !hit;
  assign instr_valid = hit;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = {addr_q, 2'b00};
  assign fetch_err    = err_q;

  always_comb begin
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    state_d = state_q;
    kind_d  = kind_q;
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (hitn && !hitc) begin
      cur_d   = nxt_q;
      nxt_d.v = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          req_d   = 1'b1;
          addr_d  = pc_tag;
          kind_d  = DEMAND;
          state_d = BUSY;
        end else if (pref_need) begin
          req_d   = 1'b1;
          addr_d  = eff_tag + 30'd1;
          kind_d  = PREF;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          cnt_d   = '0;
          // A word matching the live PC is adopted whatever its kind.
          if (addr_q == pc_tag) begin
            cur_d.tag  = addr_q;
            cur_d.data = mem.mem_rdata;
            cur_d.v    = 1'b1;
          end else if (kind_q == PREF) begin
            nxt_d.tag  = addr_q;
            nxt_d.data = mem.mem_rdata;
            nxt_d.v    = 1'b1;
          end
        end else begin
          if (cnt_q != CW'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q >= CW'(TIMEOUT - 1)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q   <= '0;
      nxt_q   <= '0;
      state_q <= IDLE;
      kind_q  <= DEMAND;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      state_q <= state_d;
      kind_q  <= kind_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of the two-entry instruction fetch stage
// against a memory image and the fetch stage's observable rules.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        fetch_err;

  instr_fetch_if bus ();

  instr_fetch #(
    .TIMEOUT  (8),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .fetch_err  (fetch_err),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  int unsigned r;
  logic        last_stall;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;
  int          stall_run;
  int          valid_cnt;

  initial begin
    reset         = 1'b1;
    pc            = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    // reset state, then first demand fetch
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 1);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_err", fetch_err, 0);
    tick();
    @(negedge clk);
    chk("t1_req", bus.mem_req, 1);
    chk("t1_addr", bus.mem_addr, 0);
    chk("t1_stall", stall, 1);
    chk("t1_instr", instr, NOP);

    // cold miss at 0x100, ack three cycles after request
    reset = 1'b1;
    pc    = 32'h100;
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_req", bus.mem_req, 1);
    chk("t2_addr", bus.mem_addr, 32'h100);
    tick();
    tick();
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hE3A01005;
    @(negedge clk);
    chk("t2_ackcyc_stall", stall, 1);
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t2_stall", stall, 0);
    chk("t2_valid", instr_valid, 1);
    chk("t2_instr", instr, 32'hE3A01005);
    chk("t2_req_drop", bus.mem_req, 0);
    tick();
    @(negedge clk);
    chk("t2_pref_req", bus.mem_req, 1);
    chk("t2_pref_addr", bus.mem_addr, 32'h104);

    // branch to 0x200 while prefetch of 0x104 is in flight
    pc = 32'h200;
    @(negedge clk);
    chk("t4_stall0", stall, 1);
    tick();
    @(negedge clk);
    chk("t4_hold_req", bus.mem_req, 1);
    chk("t4_hold_addr", bus.mem_addr, 32'h104);
    chk("t4_stall1", stall, 1);
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11110104;
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t4_idle_req", bus.mem_req, 0);
    chk("t4_stall2", stall, 1);
    tick();
    @(negedge clk);
    chk("t4_dem_req", bus.mem_req, 1);
    chk("t4_dem_addr", bus.mem_addr, 32'h200);
    chk("t4_stall3", stall, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h22220200;
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t4_stall4", stall, 0);
    chk("t4_instr", instr, 32'h22220200);
    tick();
    pc = 32'h104;
    @(negedge clk);
    chk("t4_nxt_hit", stall, 0);
    chk("t4_nxt_instr", instr, 32'h11110104);
    chk("t4_pref2_addr", bus.mem_addr, 32'h204);

    // timeout with ack stuck low
    reset = 1'b1;
    pc    = 32'h300;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t5_err_low", fetch_err, 0);
      tick();
    end
    @(negedge clk);
    chk("t5_err_set", fetch_err, 1);
    chk("t5_req_held", bus.mem_req, 1);
    chk("t5_addr_held", bus.mem_addr, 32'h300);
    repeat (5) tick();
    @(negedge clk);
    chk("t5_err_sticky", fetch_err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_err", fetch_err, 0);
    chk("t5_rst_req", bus.mem_req, 0);

    // reset in the middle of a transaction, late ack ignored
    reset = 1'b1;
    pc    = 32'h400;
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_req", bus.mem_req, 1);
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t6_req_drop", bus.mem_req, 0);
    chk("t6_stall", stall, 1);
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t6_refetch_req", bus.mem_req, 1);
    chk("t6_refetch_addr", bus.mem_addr, 32'h400);
    chk("t6_still_stall", stall, 1);
    chk("t6_no_late_data", instr, NOP);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h44440400;
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t6_stall_clr", stall, 0);
    chk("t6_instr", instr, 32'h44440400);

    // randomized program flow against a memory image
    reset = 1'b1;
    pc    = 32'h0;
    tick();
    reset      = 1'b0;
    last_stall = 1'b1;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = 32'h0;
    stall_run  = 0;
    valid_cnt  = 0;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      if (!last_stall) begin
        if (r < 85) pc = (pc + 32'd4) & 32'h3FC;
        else        pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end else if (r < 5) begin
        pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
      bus.mem_ack   = bus.mem_req && ($urandom_range(0, 3) != 0);
      bus.mem_rdata = bus.mem_ack ? memf(bus.mem_addr) : $urandom();
      @(negedge clk);
      if (!stall) begin
        chk("rnd_instr", instr, memf(pc));
        valid_cnt++;
        stall_run = 0;
      end else begin
        chk("rnd_nop", instr, NOP);
        stall_run++;
      end
      chk("rnd_valid", instr_valid, !stall);
      chk("rnd_align", bus.mem_addr[1:0], 0);
      if (prev_req && !prev_ack) begin
        chk("rnd_req_hold", bus.mem_req, 1);
        chk("rnd_addr_hold", bus.mem_addr, prev_addr);
      end
      chk("rnd_live", stall_run <= 40, 1);
      last_stall = stall;
      prev_req   = bus.mem_req;
      prev_ack   = bus.mem_ack;
      prev_addr  = bus.mem_addr;
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("rnd_progress", valid_cnt > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
